// File: rtl/counter_mod_pkg.sv
// Shared constants for the counter family: mode encodings, default widths
// and the per-cycle action selector used by the counter core.
package cnt_pkg;

    // dir encodings
    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    // sat encodings
    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // default widths
    localparam int CNT_CW_DEF = 8;
    localparam int CNT_PW_DEF = 4;

    // What the counter register does this cycle, in priority order
    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_CLR  = 2'd1,
        ACT_LOAD = 2'd2,
        ACT_STEP = 2'd3
    } cnt_act_e;

endpackage

// File: rtl/counter_mod_if.sv
// Control/status bundle of the counter. The master side (status logic or a
// bus wrapper) drives the controls; the slave side is the counter itself.
interface counter_mod_if #(
    parameter int CW = 8,
    parameter int PW = 4
);
    logic          en;
    logic          dir;
    logic          sat;
    logic [PW-1:0] div;
    logic [CW-1:0] limit;
    logic          clr;
    logic          load;
    logic [CW-1:0] load_val;
    logic          clr_flags;
    logic [CW-1:0] c_out;
    logic          tc;
    logic          ovf;

    modport master (
        output en, dir, sat, div, limit, clr, load, load_val, clr_flags,
        input  c_out, tc, ovf
    );

    modport slave (
        input  en, dir, sat, div, limit, clr, load, load_val, clr_flags,
        output c_out, tc, ovf
    );
endinterface

// File: rtl/counter_mod_prescaler.sv
// Clock-enable prescaler: emits one step every div+1 enabled cycles.
// A phase beyond a freshly lowered div fires on the next enabled cycle
// instead of running all the way round the PW-bit range.
module cnt_prescaler #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] div,
    output logic          step
);

    logic [PW-1:0] p_q;

    // >= rather than == so a phase stranded above div recovers in one cycle
    assign step = en && (p_q >= div);

    // Phase counter: cleared by clr, advances or restarts only while enabled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            p_q <= '0;
        else if (clr)
            p_q <= '0;
        else if (en)
            p_q <= step ? '0 : p_q + PW'(1);
    end

endmodule

// File: rtl/counter_mod.sv
// Up/down counter with programmable modulo limit, wrap/saturate mode,
// prescaled stepping, synchronous clear/load, registered terminal-count
// pulse and sticky overflow flag.
module counter_mod
    import cnt_pkg::*;
#(
    parameter int            CW      = CNT_CW_DEF,
    parameter int            PW      = CNT_PW_DEF,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          resetn,
    counter_mod_if.slave  bus
);

    logic [CW-1:0] c_q, c_nxt;
    logic          tc_q, ovf_q;
    logic          step;
    logic          evt;
    logic [CW-1:0] load_clamped;
    cnt_act_e      act;

    // Load also restarts the prescaler so the first step after a load
    // takes a full div+1 enabled cycles.
    cnt_prescaler #(.PW(PW)) u_presc (
        .clk    (clk),
        .resetn (resetn),
        .en     (bus.en),
        .clr    (bus.clr | bus.load),
        .div    (bus.div),
        .step   (step)
    );

    assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

    // Priority select: clear beats load beats step
    always_comb begin
        act = ACT_HOLD;
        if (bus.clr)
            act = ACT_CLR;
        else if (bus.load)
            act = ACT_LOAD;
        else if (step)
            act = ACT_STEP;
    end

    // Next count and boundary detection; limit is compared before any
    // increment/decrement so the arithmetic never leaves CW bits.
    always_comb begin
        c_nxt = c_q;
        evt   = 1'b0;
        unique case (act)
            ACT_CLR:  c_nxt = '0;
            ACT_LOAD: c_nxt = load_clamped;
            ACT_STEP: begin
                if (bus.dir == CNT_UP) begin
                    if (c_q < bus.limit) begin
                        c_nxt = c_q + CW'(1);
                    end else begin
                        evt   = 1'b1;
                        c_nxt = (bus.sat == CNT_SAT) ? bus.limit : '0;
                    end
                end else begin
                    if (c_q == '0) begin
                        evt   = 1'b1;
                        c_nxt = (bus.sat == CNT_SAT) ? '0 : bus.limit;
                    end else if (c_q > bus.limit) begin
                        // limit was lowered under us: snap down, not an event
                        c_nxt = bus.limit;
                    end else begin
                        c_nxt = c_q - CW'(1);
                    end
                end
            end
            default:  c_nxt = c_q;
        endcase
    end

    // Count register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            c_q <= RST_VAL;
        else
            c_q <= c_nxt;
    end

    // tc echoes the boundary event one cycle later; ovf is sticky, set wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tc_q <= evt;
            if (evt)
                ovf_q <= 1'b1;
            else if (bus.clr_flags)
                ovf_q <= 1'b0;
        end
    end

    assign bus.c_out = c_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: directed vector table for the scripted scenarios,
// a hand-written async-reset sequence, then randomized traffic checked
// against an integer reference model.
module tb_counter_mod;

    logic clk;
    logic resetn;

    counter_mod_if #(.CW(8), .PW(4)) bus ();

    counter_mod #(.CW(8), .PW(4), .RST_VAL(8'd0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string nm;
        bit    en, dir, sat;
        int    div, lim;
        bit    clr, load;
        int    lv;
        bit    cf;
        int    ec;
        bit    etc, eo;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int m_c, m_p;
    bit m_tc, m_ovf;

    function automatic void add(string nm, bit en, bit dir, bit sat, int div, int lim,
                                bit clr, bit load, int lv, bit cf,
                                int ec, bit etc, bit eo);
        vec_t v;
        v.nm = nm; v.en = en; v.dir = dir; v.sat = sat; v.div = div; v.lim = lim;
        v.clr = clr; v.load = load; v.lv = lv; v.cf = cf;
        v.ec = ec; v.etc = etc; v.eo = eo;
        vq.push_back(v);
    endfunction

    task automatic chk(string nm, int ec, bit etc, bit eo);
        n_cmp++;
        if (int'(bus.c_out) != ec || bus.tc !== etc || bus.ovf !== eo) begin
            n_bad++;
            $display("FAIL %s: got c_out=%0d tc=%0b ovf=%0b, want c_out=%0d tc=%0b ovf=%0b",
                     nm, bus.c_out, bus.tc, bus.ovf, ec, etc, eo);
        end
    endtask

    // Advance the model by one clock from the current inputs, then the DUT
    task automatic cyc();
        int  lim, c, p;
        bit  ev, fire;
        lim = int'(bus.limit);
        c = m_c; p = m_p; ev = 1'b0;
        if (bus.clr) begin
            c = 0; p = 0;
        end else if (bus.load) begin
            c = (int'(bus.load_val) < lim) ? int'(bus.load_val) : lim;
            p = 0;
        end else if (bus.en) begin
            fire = (p >= int'(bus.div));
            p = fire ? 0 : p + 1;
            if (fire) begin
                if (bus.dir) begin
                    if (c < lim) c = c + 1;
                    else begin ev = 1'b1; c = bus.sat ? lim : 0; end
                end else begin
                    if (c == 0) begin ev = 1'b1; c = bus.sat ? 0 : lim; end
                    else if (c > lim) c = lim;
                    else c = c - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        m_c = c; m_p = p; m_tc = ev;
        m_ovf = ev | (m_ovf & ~bus.clr_flags);
    endtask

    task automatic drive(bit en, bit dir, bit sat, int div, int lim,
                         bit clr, bit load, int lv, bit cf);
        bus.en = en; bus.dir = dir; bus.sat = sat; bus.div = 4'(div);
        bus.limit = 8'(lim); bus.clr = clr; bus.load = load;
        bus.load_val = 8'(lv); bus.clr_flags = cf;
    endtask

    task automatic model_reset();
        m_c = 0; m_p = 0; m_tc = 1'b0; m_ovf = 1'b0;
    endtask

    initial begin
        drive(0, 1, 0, 0, 255, 0, 0, 0, 0);
        resetn = 1'b0;
        model_reset();
        #12;
        chk("reset", 0, 0, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // 1: wrap up-count to limit 9
        for (int k = 1; k <= 12; k++)
            add("t1_wrap_up", 1, 1, 0, 0, 9, 0, 0, 0, 0, k % 10, k == 10, k >= 10);
        // 2: prescaler div=3 and en hold
        add("t2_clr", 1, 1, 0, 3, 255, 1, 0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 16; k++)
            add("t2_presc", 1, 1, 0, 3, 255, 0, 0, 0, 0, k / 4, 0, 1);
        add("t2_phase", 1, 1, 0, 3, 255, 0, 0, 0, 0, 4, 0, 1);
        add("t2_phase", 1, 1, 0, 3, 255, 0, 0, 0, 0, 4, 0, 1);
        for (int k = 0; k < 5; k++)
            add("t2_en_hold", 0, 1, 0, 3, 255, 0, 0, 0, 0, 4, 0, 1);
        add("t2_resume", 1, 1, 0, 3, 255, 0, 0, 0, 0, 4, 0, 1);
        add("t2_resume", 1, 1, 0, 3, 255, 0, 0, 0, 0, 5, 0, 1);
        // 3: saturate down from 2
        add("t3_load_cf", 0, 0, 1, 0, 9, 0, 1, 2, 1, 2, 0, 0);
        add("t3_sat_dn", 1, 0, 1, 0, 9, 0, 0, 0, 0, 1, 0, 0);
        add("t3_sat_dn", 1, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++)
            add("t3_sat_bound", 1, 0, 1, 0, 9, 0, 0, 0, 0, 0, 1, 1);
        add("t3_cf_vs_evt", 1, 0, 1, 0, 9, 0, 0, 0, 1, 0, 1, 1);
        add("t3_cf_alone", 0, 0, 1, 0, 9, 0, 0, 0, 1, 0, 0, 0);
        // 4: clr beats load; load clamps to limit
        add("t4_clr_load", 1, 1, 0, 0, 100, 1, 1, 200, 0, 0, 0, 0);
        add("t4_load_clamp", 1, 1, 0, 0, 100, 0, 1, 200, 0, 100, 0, 0);
        // 5: limit lowered below count
        add("t5_load50", 0, 1, 0, 0, 100, 0, 1, 50, 0, 50, 0, 0);
        add("t5_up_over", 1, 1, 0, 0, 20, 0, 0, 0, 0, 0, 1, 1);
        add("t5_load50b", 0, 0, 0, 0, 100, 0, 1, 50, 0, 50, 0, 1);
        add("t5_dn_snap", 1, 0, 0, 0, 20, 0, 0, 0, 0, 20, 0, 1);
        add("t5_hold", 0, 0, 0, 0, 20, 0, 0, 0, 0, 20, 0, 1);
        // limit = 0: every step is a boundary event
        add("lim0_up", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add("lim0_up", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add("lim0_dn_sat", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].dir, vq[i].sat, vq[i].div, vq[i].lim,
                  vq[i].clr, vq[i].load, vq[i].lv, vq[i].cf);
            cyc();
            chk(vq[i].nm, vq[i].ec, vq[i].etc, vq[i].eo);
        end

        // 6: async reset mid-count with div=2, then first step on 3rd enabled cycle
        drive(1, 1, 0, 2, 255, 0, 0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc();
            chk("t6_pre", k / 3, 0, 1);
        end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("t6_async_rst", 0, 0, 0);
        @(posedge clk); #1;
        chk("t6_rst_held", 0, 0, 0);
        resetn = 1'b1;
        cyc(); chk("t6_post1", 0, 0, 0);
        cyc(); chk("t6_post2", 0, 0, 0);
        cyc(); chk("t6_post3", 1, 0, 0);

        // randomized traffic against the model
        begin
            int lim;
            lim = 9;
            drive(0, 1, 0, 0, lim, 0, 0, 0, 0);
            resetn = 1'b0;
            model_reset();
            #3;
            resetn = 1'b1;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 19) == 0)
                    lim = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 12));
                drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), lim,
                      $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
                      int'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
                cyc();
                chk("rand", m_c, m_tc, m_ovf);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
